iterative_divider: RTL and testbench

Parametrised, self-contained radix-2 sequential integer divider: datapath, control FSM and iteration counter in one block. It generalises the fixed 32-bit divider datapath to any width, computes signed or unsigned quotient and remainder, and handles divide-by-zero and signed overflow in hardware. It sits behind the multiply/division unit's operand registers and talks to the issuing logic through a start/busy/done handshake with flush.

---
 rtl/iterative_divider_if.sv | 26 ++
 rtl/iterative_divider.sv | 135 +++++++++++++
 tb/tb_iterative_divider.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// Start/busy/done handshake and operand/result bus between the issuing logic and
// the iterative divider.
interface iterative_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             usigned;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] reminder;
    logic             dz;

    modport master (
        output start, usigned, dividend, divisor, flush,
        input  busy, done, quotient, reminder, dz
    );

    modport slave (
        input  start, usigned, dividend, divisor, flush,
        output busy, done, quotient, reminder, dz
    );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 non-restoring sequential divider, signed or unsigned, with divide-by-zero
// and signed-overflow fast paths and a start/busy/done/flush handshake.
module iterative_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst_n,
    iterative_divider_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StCorr, StDone} state_e;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] reminder_q, reminder_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg, div_zero, ovf, accept;
    logic [WIDTH-1:0] a_mag, b_mag, rem_mag;
    logic [WIDTH:0]   p_sh, p_step, p_fix;

    always_comb begin
        a_neg    = ~bus.usigned & bus.dividend[WIDTH-1];
        b_neg    = ~bus.usigned & bus.divisor[WIDTH-1];
        // |MIN| is 2^(WIDTH-1), which still fits as an unsigned magnitude
        a_mag    = a_neg ? -bus.dividend : bus.dividend;
        b_mag    = b_neg ? -bus.divisor : bus.divisor;
        div_zero = (bus.divisor == '0);
        ovf      = ~bus.usigned & (bus.dividend == MinVal) & (bus.divisor == '1);
        accept   = bus.start & ~bus.flush & ((state_q == StIdle) | (state_q == StDone));
        // Sign decision uses the pre-shift P so modular wrap of the shift is harmless
        p_sh     = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        p_step   = p_q[WIDTH] ? p_sh + {1'b0, d_q} : p_sh - {1'b0, d_q};
        p_fix    = p_q[WIDTH] ? p_q + {1'b0, d_q} : p_q;
        rem_mag  = p_fix[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        q_d        = q_q;
        d_d        = d_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        quotient_d = quotient_q;
        reminder_d = reminder_q;
        dz_d       = dz_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    dz_d = div_zero;
                    if (div_zero) begin
                        quotient_d = '1;
                        reminder_d = bus.dividend;
                        state_d    = StDone;
                    end else if (ovf) begin
                        quotient_d = bus.dividend;
                        reminder_d = '0;
                        state_d    = StDone;
                    end else begin
                        p_d       = '0;
                        q_d       = a_mag;
                        d_d       = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    p_d   = p_step;
                    q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = StCorr;
                end
            end
            StCorr: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    quotient_d = neg_quo_q ? -q_q : q_q;
                    reminder_d = neg_rem_q ? -rem_mag : rem_mag;
                    state_d    = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            p_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            quotient_q <= '0;
            reminder_q <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            q_q        <= q_d;
            d_q        <= d_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            quotient_q <= quotient_d;
            reminder_q <= reminder_d;
            dz_q       <= dz_d;
        end
    end

    assign bus.busy     = (state_q == StCalc) || (state_q == StCorr);
    assign bus.done     = (state_q == StDone);
    assign bus.quotient = quotient_q;
    assign bus.reminder = reminder_q;
    assign bus.dz       = dz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider (WIDTH=32) against an arithmetic
// reference model.
module tb_iterative_divider;
    localparam int unsigned W = 32;
    localparam logic [31:0] MinVal = 32'h8000_0000;
    localparam int NormLat = W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truncating division; SV longint / and % already round toward zero
    function automatic void model(input bit us, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = NormLat;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else begin
            dz = 1'b0;
            if (us) begin
                q = a / b;
                r = a % b;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                if (a == MinVal && b == '1) lat = 1;
            end
        end
    endfunction

    // Called #1 after a rising edge; returns after the edge where done is seen
    task automatic do_op(input bit us, input logic [31:0] a, input logic [31:0] b,
                         input int ign_at, output int lat, output int busy_cnt,
                         output bit got);
        bus.start = 1'b1; bus.usigned = us; bus.dividend = a; bus.divisor = b;
        lat = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
            if (lat == ign_at) begin
                bus.start = 1'b1; bus.usigned = 1'b1; bus.dividend = 1; bus.divisor = 1;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic run_check(input string tag, input bit us, input logic [31:0] a,
                             input logic [31:0] b);
        logic [31:0] eq, er;
        logic edz;
        int elat, lat, bc;
        bit got;
        model(us, a, b, eq, er, edz, elat);
        do_op(us, a, b, 0, lat, bc, got);
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_q"}, 64'(bus.quotient), 64'(eq));
        check({tag, "_r"}, 64'(bus.reminder), 64'(er));
        check({tag, "_dz"}, 64'(bus.dz), 64'(edz));
        check({tag, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        int lat, bc;
        bit got, seen;
        logic [31:0] ra, rb;
        bit rus;

        bus.start = 1'b0; bus.usigned = 1'b1; bus.flush = 1'b0;
        bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.dz), 64'd0);
        check("rst_q", 64'(bus.quotient), 64'd0);
        check("rst_r", 64'(bus.reminder), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100/7 with spec-literal results and timing
        do_op(1'b1, 100, 7, 0, lat, bc, got);
        check("u100_7_q", 64'(bus.quotient), 64'd14);
        check("u100_7_r", 64'(bus.reminder), 64'd2);
        check("u100_7_dz", 64'(bus.dz), 64'd0);
        check("u100_7_lat", 64'(lat), 64'd34);
        check("u100_7_busy", 64'(bc), 64'd33);
        @(posedge clk); #1;
        check("done_pulse", 64'(bus.done), 64'd0);

        run_check("s_m7_2", 1'b0, -32'sd7, 2);
        check("s_m7_2_lit", 64'(bus.quotient), 64'hFFFF_FFFD);
        run_check("s_7_m2", 1'b0, 7, -32'sd2);
        check("s_7_m2_lit", 64'(bus.reminder), 64'd1);
        run_check("u_max_1", 1'b1, 32'hFFFF_FFFF, 1);
        run_check("u_5_0", 1'b1, 5, 0);
        run_check("s_5_0", 1'b0, 5, 0);
        check("s_5_0_q_lit", 64'(bus.quotient), 64'hFFFF_FFFF);
        run_check("s_9_3", 1'b0, 9, 3);
        run_check("s_ovf", 1'b0, MinVal, 32'hFFFF_FFFF);
        check("s_ovf_q_lit", 64'(bus.quotient), 64'h8000_0000);
        run_check("u_min_m1", 1'b1, MinVal, 32'hFFFF_FFFF);

        // Start while busy is ignored
        do_op(1'b1, 100, 7, 5, lat, bc, got);
        check("ign_q", 64'(bus.quotient), 64'd14);
        check("ign_r", 64'(bus.reminder), 64'd2);
        check("ign_lat", 64'(lat), 64'd34);
        // Back-to-back start in the done cycle
        run_check("b2b", 1'b1, 1000, 33);

        // Flush mid-CALC: no done, results preserved
        run_check("pre_flush", 1'b1, 100, 7);
        bus.start = 1'b1; bus.usigned = 1'b1; bus.dividend = 50; bus.divisor = 3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("flush_nodone", 64'(seen), 64'd0);
        check("flush_q", 64'(bus.quotient), 64'd14);
        check("flush_r", 64'(bus.reminder), 64'd2);

        // Flush together with start in IDLE: start dropped
        bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 5; bus.divisor = 0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("fs_busy", 64'(bus.busy), 64'd0);
        check("fs_done", 64'(bus.done), 64'd0);
        check("fs_dz", 64'(bus.dz), 64'd0);

        // Random operands with edge-value bias
        for (int n = 0; n < 40; n++) begin
            rus = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: begin ra = MinVal; rb = '1; end
                2: rb = 1;
                3: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
                4: rb = $urandom_range(1, 7);
                default: ;
            endcase
            run_check($sformatf("rnd%0d", n), rus, ra, rb);
        end

        // Reset mid-CALC clears all outputs
        run_check("pre_rst", 1'b0, 5, 0);
        bus.start = 1'b1; bus.usigned = 1'b1; bus.dividend = 100; bus.divisor = 7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_done", 64'(bus.done), 64'd0);
        check("mrst_dz", 64'(bus.dz), 64'd0);
        check("mrst_q", 64'(bus.quotient), 64'd0);
        check("mrst_r", 64'(bus.reminder), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
